fu_div_arbiter: RTL and testbench
=================================

Name: fu_div_arbiter

Overview:
Shares the two-lane pipelined FP16 divider in the FU cluster among NUM_REQ requesters using round-robin arbitration. At most one packed complex operand pair (two FP16 lanes in one 2*DATA_WIDTH word) issues per cycle. A tag pipeline matched to the divider latency carries each request's identity, so every result returns to the requester that issued it. The block sits between the PE-side requesters and the divider lanes; the divider is external.

Parameters:
NUM_REQ, 4, number of requesters (2..8)
DATA_WIDTH, 16, width of one FP16 lane; operand and result words are 2*DATA_WIDTH
DIV_LATENCY, 5, cycles from divider input to divider output (fixed pipeline, no stall)

Ports:
clk  in  1  clock
rst_n  in  1  synchronous active-low reset
flush  in  1  discard all in-flight operations
req_valid  in  NUM_REQ  per-requester request valid
req_ready  out  NUM_REQ  per-requester grant (one-hot or zero)
req_opa  in  NUM_REQ x 2*DATA_WIDTH  dividend word per requester
req_opb  in  NUM_REQ x 2*DATA_WIDTH  divisor word per requester
div_a  out  2*DATA_WIDTH  registered dividend to divider lanes
div_b  out  2*DATA_WIDTH  registered divisor to divider lanes
div_z  in  2*DATA_WIDTH  divider result word
rsp_valid  out  NUM_REQ  one-cycle result strobe, one-hot or zero
rsp_data  out  2*DATA_WIDTH  result word, valid while any rsp_valid bit is set
busy  out  1  high while any operation is in flight
issue_cnt  out  16  total accepted requests, wraps at 2^16

Behaviour:
- One clock domain. Reset is synchronous and active-low. The clock port is named clk and the reset port rst_n.
- Reset values:
  - ptr = 0
  - div_a = div_b = 0
  - tag pipeline cleared
  - rsp_valid = 0, rsp_data = 0
  - busy = 0, issue_cnt = 0
  - Reset asserted mid-operation drops all in-flight results; no rsp_valid is produced for them.
- Arbitration (combinational):
  - Scan from ptr upward with wrap. The first index i with req_valid[i]=1 gets req_ready[i]=1; all other ready bits are 0.
  - req_ready depends on req_valid; requesters must not make valid depend on ready.
  - Handshake completes when req_valid[i] & req_ready[i].
  - A requester holds valid and operands stable until it is granted.
  - No grant is made while rst_n=0 or flush=1.
- Pointer update:
  - On a handshake with index g, ptr <= (g+1) mod NUM_REQ.
  - With no handshake, ptr is unchanged.
  - A requester that stays valid is therefore served at least once every NUM_REQ cycles.
- Issue:
  - On a handshake in cycle t, div_a/div_b <= req_opa[g]/req_opb[g]; they are presented to the divider from cycle t+1.
  - With no handshake, div_a/div_b hold their previous values.
- Tag pipeline:
  - Shift register of depth DIV_LATENCY+1; each entry holds {valid, tag of width clog2(NUM_REQ)}.
  - Stage 0 captures {handshake, g} at each cycle edge.
  - The entry leaving the last stage aligns with div_z for that operation.
- Response:
  - When the exiting entry is valid, register rsp_valid[tag] <= 1 and rsp_data <= div_z; otherwise rsp_valid <= 0 and rsp_data holds.
  - Total latency: handshake edge at t, rsp_valid high in cycle t+DIV_LATENCY+2.
  - Responses have no backpressure.
  - Back-to-back issues produce back-to-back responses in issue order.
- flush:
  - Clears all tag-pipeline valid bits and rsp_valid in the same edge. No grant is made that cycle.
  - ptr, div_a/div_b and issue_cnt are unchanged.
  - Operations already inside the divider complete there but are never reported.
- busy = OR of all tag-pipeline valid bits, including the entry being registered into the response stage.
- issue_cnt increments by 1 per handshake and wraps 0xFFFF -> 0x0000.
- No arithmetic is performed on data; words pass through unmodified. Lane alignment is [DATA_WIDTH-1:0] and [2*DATA_WIDTH-1:DATA_WIDTH].

Test Plan:
1. Reset, then requester 0 only: opa=0x46004600 (6.0,6.0), opb=0x42003C00 (3.0,1.0), with a divider model at DIV_LATENCY=5 -> req_ready[0] in the same cycle; rsp_valid[0] exactly 7 cycles after the handshake; rsp_data=0x40004600; busy high from t+1 through the response cycle.
2. All four requesters valid continuously for 8 cycles with ptr=0 -> grant order 0,1,2,3,0,1,2,3; eight consecutive responses in the same order; issue_cnt=8.
3. Requesters 1 and 3 valid, ptr=2 -> grant 3 then 1; ptr ends at 2.
4. Issue three operations, then assert flush for one cycle two cycles later -> no rsp_valid ever fires for them; busy=0 the cycle after flush; no grant during the flush cycle; issue_cnt=3.
5. Assert rst_n=0 with operations in flight -> all outputs at reset values on the next edge; no stale responses after reset is released.
6. Preload 0xFFFE accepted requests, then issue 3 more -> issue_cnt reads 0x0001.

Source files
------------

// File: rtl/fu_div_arbiter.sv
// Round-robin arbiter sharing a two-lane pipelined FP16 divider among NUM_REQ
// requesters. A tag pipeline matched to the divider latency routes every
// result back to the requester that issued it.
module fu_div_arbiter #(
    parameter int unsigned NUM_REQ     = 4,
    parameter int unsigned DATA_WIDTH  = 16,
    parameter int unsigned DIV_LATENCY = 5
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic                              flush,
    input  logic [NUM_REQ-1:0]                req_valid,
    output logic [NUM_REQ-1:0]                req_ready,
    input  logic [NUM_REQ*2*DATA_WIDTH-1:0]   req_opa,
    input  logic [NUM_REQ*2*DATA_WIDTH-1:0]   req_opb,
    output logic [2*DATA_WIDTH-1:0]           div_a,
    output logic [2*DATA_WIDTH-1:0]           div_b,
    input  logic [2*DATA_WIDTH-1:0]           div_z,
    output logic [NUM_REQ-1:0]                rsp_valid,
    output logic [2*DATA_WIDTH-1:0]           rsp_data,
    output logic                              busy,
    output logic [15:0]                       issue_cnt
);

    localparam int unsigned WORD_W = 2 * DATA_WIDTH;
    localparam int unsigned PTR_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int unsigned DEPTH  = DIV_LATENCY + 1;
    localparam int unsigned LAST   = DEPTH - 1;

    logic [PTR_W-1:0]            ptr_q, ptr_d;
    logic [WORD_W-1:0]           div_a_q, div_a_d;
    logic [WORD_W-1:0]           div_b_q, div_b_d;
    logic [DEPTH-1:0]            tag_vld_q, tag_vld_d;
    logic [DEPTH-1:0][PTR_W-1:0] tag_idx_q, tag_idx_d;
    logic [NUM_REQ-1:0]          rsp_valid_q, rsp_valid_d;
    logic [WORD_W-1:0]           rsp_data_q, rsp_data_d;
    logic                        busy_q, busy_d;
    logic [15:0]                 issue_cnt_q, issue_cnt_d;

    logic                        gnt_vld_c;
    logic [PTR_W-1:0]            gnt_idx_c;
    logic [WORD_W-1:0]           opa_sel_c;
    logic [WORD_W-1:0]           opb_sel_c;

    // Round-robin scan from ptr upward; grants suppressed in reset and flush.
    always_comb begin
        int unsigned idx;
        idx       = 0;
        gnt_vld_c = 1'b0;
        gnt_idx_c = '0;
        req_ready = '0;
        if (rst_n && !flush) begin
            for (int unsigned k = 0; k < NUM_REQ; k++) begin
                idx = (32'(ptr_q) + k) % NUM_REQ;
                if (!gnt_vld_c && req_valid[PTR_W'(idx)]) begin
                    gnt_vld_c = 1'b1;
                    gnt_idx_c = PTR_W'(idx);
                end
            end
        end
        req_ready[gnt_idx_c] = gnt_vld_c;
    end

    // Operand select for the granted requester.
    always_comb begin
        opa_sel_c = '0;
        opb_sel_c = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (PTR_W'(i) == gnt_idx_c) begin
                opa_sel_c = req_opa[i*WORD_W +: WORD_W];
                opb_sel_c = req_opb[i*WORD_W +: WORD_W];
            end
        end
    end

    // Next state: pointer, issue registers, tag shift, response, busy.
    always_comb begin
        ptr_d       = ptr_q;
        div_a_d     = div_a_q;
        div_b_d     = div_b_q;
        issue_cnt_d = issue_cnt_q;
        tag_vld_d   = {tag_vld_q[DEPTH-2:0], gnt_vld_c};
        tag_idx_d   = {tag_idx_q[DEPTH-2:0], gnt_idx_c};
        rsp_valid_d = '0;
        rsp_data_d  = rsp_data_q;

        if (gnt_vld_c) begin
            ptr_d       = (gnt_idx_c == PTR_W'(NUM_REQ - 1)) ? '0 : gnt_idx_c + PTR_W'(1);
            div_a_d     = opa_sel_c;
            div_b_d     = opb_sel_c;
            issue_cnt_d = issue_cnt_q + 16'd1;
        end

        // The exiting tag lines up with div_z for the same operation.
        if (tag_vld_q[LAST] && !flush) begin
            for (int unsigned i = 0; i < NUM_REQ; i++) begin
                rsp_valid_d[i] = (tag_idx_q[LAST] == PTR_W'(i));
            end
            rsp_data_d = div_z;
        end

        if (flush) begin
            tag_vld_d = '0;
        end

        busy_d = (|tag_vld_d) | (tag_vld_q[LAST] & ~flush);
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ptr_q       <= '0;
            div_a_q     <= '0;
            div_b_q     <= '0;
            tag_vld_q   <= '0;
            tag_idx_q   <= '0;
            rsp_valid_q <= '0;
            rsp_data_q  <= '0;
            busy_q      <= 1'b0;
            issue_cnt_q <= '0;
        end else begin
            ptr_q       <= ptr_d;
            div_a_q     <= div_a_d;
            div_b_q     <= div_b_d;
            tag_vld_q   <= tag_vld_d;
            tag_idx_q   <= tag_idx_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
            busy_q      <= busy_d;
            issue_cnt_q <= issue_cnt_d;
        end
    end

    assign div_a     = div_a_q;
    assign div_b     = div_b_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_data  = rsp_data_q;
    assign busy      = busy_q;
    assign issue_cnt = issue_cnt_q;

endmodule

// File: tb/tb_fu_div_arbiter.sv
// Directed bench for fu_div_arbiter with a latency-5 stand-in divider model.
module tb_fu_div_arbiter;

    localparam int unsigned NUM_REQ     = 4;
    localparam int unsigned DATA_WIDTH  = 16;
    localparam int unsigned DIV_LATENCY = 5;
    localparam int unsigned WORD_W      = 2 * DATA_WIDTH;

    logic                        clk;
    logic                        rst_n;
    logic                        flush;
    logic [NUM_REQ-1:0]          req_valid;
    logic [NUM_REQ-1:0]          req_ready;
    logic [NUM_REQ*WORD_W-1:0]   req_opa;
    logic [NUM_REQ*WORD_W-1:0]   req_opb;
    logic [WORD_W-1:0]           div_a;
    logic [WORD_W-1:0]           div_b;
    logic [WORD_W-1:0]           div_z;
    logic [NUM_REQ-1:0]          rsp_valid;
    logic [WORD_W-1:0]           rsp_data;
    logic                        busy;
    logic [15:0]                 issue_cnt;

    int n_checks;
    int n_fail;

    fu_div_arbiter #(
        .NUM_REQ    (NUM_REQ),
        .DATA_WIDTH (DATA_WIDTH),
        .DIV_LATENCY(DIV_LATENCY)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .flush    (flush),
        .req_valid(req_valid),
        .req_ready(req_ready),
        .req_opa  (req_opa),
        .req_opb  (req_opb),
        .div_a    (div_a),
        .div_b    (div_b),
        .div_z    (div_z),
        .rsp_valid(rsp_valid),
        .rsp_data (rsp_data),
        .busy     (busy),
        .issue_cnt(issue_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Stand-in lane divider: exact for x/1.0 and 6.0/3.0, otherwise a marker pattern.
    function automatic logic [15:0] lane_div(input logic [15:0] a, input logic [15:0] b);
        if (b == 16'h3C00) return a;
        if (a == 16'h4600 && b == 16'h4200) return 16'h4000;
        return a ^ b;
    endfunction

    logic [WORD_W-1:0] dpipe [DIV_LATENCY];
    always @(posedge clk) begin
        dpipe[0] <= {lane_div(div_a[31:16], div_b[31:16]), lane_div(div_a[15:0], div_b[15:0])};
        for (int i = 1; i < int'(DIV_LATENCY); i++) dpipe[i] <= dpipe[i-1];
    end
    assign div_z = dpipe[DIV_LATENCY-1];

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic set_op(input int i, input logic [31:0] a, input logic [31:0] b);
        req_opa[i*WORD_W +: WORD_W] = a;
        req_opb[i*WORD_W +: WORD_W] = b;
    endtask

    task automatic do_reset();
        rst_n     = 1'b0;
        flush     = 1'b0;
        req_valid = '0;
        next_cycle();
        next_cycle();
        rst_n = 1'b1;
        next_cycle();
    endtask

    logic [31:0] opa_of [NUM_REQ];

    initial begin
        n_checks  = 0;
        n_fail    = 0;
        rst_n     = 1'b0;
        flush     = 1'b0;
        req_valid = '0;
        req_opa   = '0;
        req_opb   = '0;
        for (int i = 0; i < int'(NUM_REQ); i++) begin
            opa_of[i] = {16'h4000 + 16'(i), 16'h5000 + 16'(i)};
            set_op(i, opa_of[i], 32'h3C003C00);
        end

        // Test 1: reset values, then a single request from requester 0.
        req_valid = 4'b1111;
        next_cycle();
        next_cycle();
        #1;
        check_eq("rst_ready", 64'(req_ready), 64'h0);
        check_eq("rst_div_a", 64'(div_a), 64'h0);
        check_eq("rst_div_b", 64'(div_b), 64'h0);
        check_eq("rst_rsp_valid", 64'(rsp_valid), 64'h0);
        check_eq("rst_rsp_data", 64'(rsp_data), 64'h0);
        check_eq("rst_busy", 64'(busy), 64'h0);
        check_eq("rst_issue_cnt", 64'(issue_cnt), 64'h0);
        req_valid = '0;
        rst_n = 1'b1;
        next_cycle();
        set_op(0, 32'h46004600, 32'h42003C00);
        req_valid = 4'b0001;
        #1;
        check_eq("t1_ready", 64'(req_ready), 64'h1);
        for (int k = 1; k <= 8; k++) begin
            next_cycle();
            req_valid = '0;
            if (k == 1) begin
                check_eq("t1_div_a", 64'(div_a), 64'h46004600);
                check_eq("t1_div_b", 64'(div_b), 64'h42003C00);
                check_eq("t1_issue_cnt", 64'(issue_cnt), 64'h1);
            end
            check_eq("t1_rsp_valid", 64'(rsp_valid), (k == 7) ? 64'h1 : 64'h0);
            check_eq("t1_busy", 64'(busy), (k <= 7) ? 64'h1 : 64'h0);
            if (k == 7) check_eq("t1_rsp_data", 64'(rsp_data), 64'h40004600);
        end
        set_op(0, opa_of[0], 32'h3C003C00);

        // Test 2: all requesters valid for 8 cycles; grants and responses rotate.
        do_reset();
        for (int k = 0; k < 16; k++) begin
            req_valid = (k < 8) ? 4'b1111 : 4'b0000;
            #1;
            if (k < 8) check_eq("t2_ready", 64'(req_ready), 64'(4'b0001 << (k % 4)));
            if (k >= 7 && k < 15) begin
                check_eq("t2_rsp_valid", 64'(rsp_valid), 64'(4'b0001 << ((k - 7) % 4)));
                check_eq("t2_rsp_data", 64'(rsp_data), 64'(opa_of[(k - 7) % 4]));
            end else begin
                check_eq("t2_rsp_idle", 64'(rsp_valid), 64'h0);
            end
            next_cycle();
        end
        check_eq("t2_issue_cnt", 64'(issue_cnt), 64'h8);

        // Test 3: requesters 1 and 3 with ptr=2 -> grant 3 then 1, ptr back to 2.
        do_reset();
        req_valid = 4'b0010;
        #1;
        check_eq("t3_pre_ready", 64'(req_ready), 64'h2);
        next_cycle();
        req_valid = 4'b1010;
        #1;
        check_eq("t3_ready_3", 64'(req_ready), 64'h8);
        next_cycle();
        req_valid = 4'b0010;
        #1;
        check_eq("t3_ready_1", 64'(req_ready), 64'h2);
        next_cycle();
        req_valid = 4'b1111;
        #1;
        check_eq("t3_ptr_is_2", 64'(req_ready), 64'h4);
        req_valid = '0;
        for (int k = 4; k <= 10; k++) begin
            next_cycle();
            case (k)
                7: check_eq("t3_rsp0", 64'(rsp_valid), 64'h2);
                8: check_eq("t3_rsp1", 64'(rsp_valid), 64'h8);
                9: check_eq("t3_rsp2", 64'(rsp_valid), 64'h2);
                default: check_eq("t3_rsp_idle", 64'(rsp_valid), 64'h0);
            endcase
            if (k == 8) check_eq("t3_rsp1_data", 64'(rsp_data), 64'(opa_of[3]));
        end

        // Test 4: three issues, flush two cycles later -> nothing reported.
        do_reset();
        for (int k = 0; k < 3; k++) begin
            set_op(0, 32'h11110001 + 32'(k), 32'h3C003C00);
            req_valid = 4'b0001;
            next_cycle();
        end
        req_valid = '0;
        next_cycle();
        flush = 1'b1;
        req_valid = 4'b1111;
        #1;
        check_eq("t4_no_grant", 64'(req_ready), 64'h0);
        next_cycle();
        flush = 1'b0;
        req_valid = '0;
        check_eq("t4_busy", 64'(busy), 64'h0);
        check_eq("t4_issue_cnt", 64'(issue_cnt), 64'h3);
        check_eq("t4_div_a_hold", 64'(div_a), 64'h11110003);
        for (int k = 0; k < 10; k++) begin
            check_eq("t4_no_rsp", 64'(rsp_valid), 64'h0);
            next_cycle();
        end
        set_op(0, opa_of[0], 32'h3C003C00);

        // Test 5: reset with operations in flight.
        do_reset();
        req_valid = 4'b0100;
        next_cycle();
        next_cycle();
        req_valid = '0;
        next_cycle();
        next_cycle();
        check_eq("t5_busy_before", 64'(busy), 64'h1);
        rst_n = 1'b0;
        next_cycle();
        check_eq("t5_rst_div_a", 64'(div_a), 64'h0);
        check_eq("t5_rst_busy", 64'(busy), 64'h0);
        check_eq("t5_rst_issue_cnt", 64'(issue_cnt), 64'h0);
        check_eq("t5_rst_rsp_data", 64'(rsp_data), 64'h0);
        rst_n = 1'b1;
        for (int k = 0; k < 10; k++) begin
            check_eq("t5_no_rsp", 64'(rsp_valid), 64'h0);
            next_cycle();
        end

        // Test 6: issue counter wraps 0xFFFF -> 0x0000.
        do_reset();
        req_valid = 4'b0001;
        for (int k = 0; k < 65534; k++) next_cycle();
        check_eq("t6_cnt_fffe", 64'(issue_cnt), 64'hFFFE);
        next_cycle();
        check_eq("t6_cnt_ffff", 64'(issue_cnt), 64'hFFFF);
        next_cycle();
        check_eq("t6_cnt_0000", 64'(issue_cnt), 64'h0000);
        next_cycle();
        req_valid = '0;
        check_eq("t6_cnt_0001", 64'(issue_cnt), 64'h0001);
        next_cycle();

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
